stopwatch_ctrl: RTL and testbench

Sequencing controller for the stopwatch datapath. It takes debounced button pulses and switch levels, runs the IDLE/RUN/PAUSE/ADJUST mode FSM, and generates the 1 Hz count tick and the adjust-rate tick. It owns the mm:ss BCD time registers. Its digit values and blank mask feed master_control's seven-segment multiplexer.

---
 rtl/stopwatch_pkg.sv | 47 ++++
 rtl/stopwatch_ctrl_if.sv | 38 +++
 rtl/sw_tick_div.sv | 32 +++
 rtl/stopwatch_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants and BCD helpers for the stopwatch controller.
package stopwatch_pkg;

  // FSM state encoding (also driven out on the debug state port)
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_PAUSE  = 2'b10;
  localparam logic [1:0] ST_ADJUST = 2'b11;

  // BCD digit limits for a 00-59 field
  localparam logic [3:0] BCD_MAX_ONES = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS = 4'd5;

  // Per-digit blank masks, order {min_tens, min_ones, sec_tens, sec_ones}
  localparam logic [3:0] BLANK_SEC  = 4'b0011;
  localparam logic [3:0] BLANK_MIN  = 4'b1100;
  localparam logic [3:0] BLANK_NONE = 4'b0000;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_pair_t;

  typedef struct packed {
    bcd_pair_t min;
    bcd_pair_t sec;
  } bcd_time_t;

  // True when a 00-59 pair sits at 59 and the next increment wraps
  function automatic logic bcd_pair_at_max(input bcd_pair_t p);
    return (p.tens == BCD_MAX_TENS) && (p.ones == BCD_MAX_ONES);
  endfunction

  // Increment a 00-59 BCD pair, wrapping 59 -> 00
  function automatic bcd_pair_t bcd_pair_inc(input bcd_pair_t p);
    bcd_pair_t r;
    r = p;
    if (p.ones >= BCD_MAX_ONES) begin
      r.ones = 4'd0;
      r.tens = (p.tens >= BCD_MAX_TENS) ? 4'd0 : p.tens + 4'd1;
    end else begin
      r.ones = p.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button/switch inputs and display outputs of the stopwatch controller.
// Optional lap_btn exists only when STOPWATCH_LAP_EN is defined.
interface stopwatch_ctrl_if;
  logic       pause_btn;
  logic       reset_btn;
  logic       adj_sw;
  logic       sel_sw;
`ifdef STOPWATCH_LAP_EN
  logic       lap_btn;
`endif
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [3:0] blank;
  logic       running;
  logic [1:0] state;

`ifdef STOPWATCH_LAP_EN
  modport master (
    output pause_btn, reset_btn, adj_sw, sel_sw, lap_btn,
    input  min_tens, min_ones, sec_tens, sec_ones, blank, running, state
  );
  modport slave (
    input  pause_btn, reset_btn, adj_sw, sel_sw, lap_btn,
    output min_tens, min_ones, sec_tens, sec_ones, blank, running, state
  );
`else
  modport master (
    output pause_btn, reset_btn, adj_sw, sel_sw,
    input  min_tens, min_ones, sec_tens, sec_ones, blank, running, state
  );
  modport slave (
    input  pause_btn, reset_btn, adj_sw, sel_sw,
    output min_tens, min_ones, sec_tens, sec_ones, blank, running, state
  );
`endif
endinterface

// File: rtl/sw_tick_div.sv
// Modulo-N tick divider: counts while enabled, synchronous clear,
// tick_c is high for the single cycle the counter sits at N-1.
module sw_tick_div #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] TERM = CW'(N - 1);

  logic [CW-1:0] cnt_q;

  // Terminal-count pulse; a same-cycle clear does not suppress it
  assign tick_c = en && (cnt_q == TERM);

  // Modulo counter with clear priority over enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick_c ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: IDLE/RUN/PAUSE/ADJUST mode FSM,
// count/adjust/blink tick generation and the mm:ss BCD time registers.
// Define STOPWATCH_LAP_EN to add the lap_btn display-hold feature.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CNT_DIV   = 100000000,
  parameter int unsigned ADJ_DIV   = 50000000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic           clk,
  input  logic           rst,
  stopwatch_ctrl_if.slave sw
);

  logic [1:0] state_q, state_d;
  bcd_time_t  time_q, time_d;
  logic       blink_phase_q, blink_phase_d;
  logic [3:0] blank_q, blank_d;
  logic       running_q, running_d;
  logic       sel_q;

  logic       cnt_tick_c, adj_tick_c, blink_tick_c;
  logic       state_chg_c, sel_chg_c;
  logic       cnt_clr_c, adj_clr_c, blink_clr_c;

  // Divider enables follow the current mode; clears on any mode change or reset_btn
  assign state_chg_c = (state_d != state_q);
  assign sel_chg_c   = (sw.sel_sw != sel_q);
  assign cnt_clr_c   = state_chg_c || sw.reset_btn;
  assign adj_clr_c   = state_chg_c || sw.reset_btn || sel_chg_c;
  assign blink_clr_c = state_chg_c || sw.reset_btn;

  sw_tick_div #(.N(CNT_DIV)) u_cnt_div (
    .clk    (clk),
    .rst_n  (rst),
    .en     (state_q == ST_RUN),
    .clr    (cnt_clr_c),
    .tick_c (cnt_tick_c)
  );

  sw_tick_div #(.N(ADJ_DIV)) u_adj_div (
    .clk    (clk),
    .rst_n  (rst),
    .en     (state_q == ST_ADJUST),
    .clr    (adj_clr_c),
    .tick_c (adj_tick_c)
  );

  sw_tick_div #(.N(BLINK_DIV)) u_blink_div (
    .clk    (clk),
    .rst_n  (rst),
    .en     (state_q == ST_ADJUST),
    .clr    (blink_clr_c),
    .tick_c (blink_tick_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next register values; reset_btn > adj_sw > pause_btn
  always_comb begin
    state_d       = state_q;
    time_d        = time_q;
    blink_phase_d = 1'b0;
    blank_d       = BLANK_NONE;
    running_d     = 1'b0;

    if (sw.reset_btn) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_ADJUST) begin
      if (!sw.adj_sw) begin
        state_d = ST_PAUSE;
      end
    end else if (sw.adj_sw) begin
      state_d = ST_ADJUST;
    end else if (sw.pause_btn) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end

    // Time update: a count tick lands even when the mode changes this cycle
    if (sw.reset_btn) begin
      time_d = '0;
    end else if (cnt_tick_c) begin
      time_d.sec = bcd_pair_inc(time_q.sec);
      if (bcd_pair_at_max(time_q.sec)) begin
        time_d.min = bcd_pair_inc(time_q.min);
      end
    end else if (adj_tick_c && !sel_chg_c) begin
      if (sw.sel_sw) begin
        time_d.min = bcd_pair_inc(time_q.min);
      end else begin
        time_d.sec = bcd_pair_inc(time_q.sec);
      end
    end

    // Blink phase only lives in ADJUST and drops to 0 on the way out
    if (state_d == ST_ADJUST) begin
      blink_phase_d = blink_phase_q ^ blink_tick_c;
    end
    if (blink_phase_d) begin
      blank_d = sw.sel_sw ? BLANK_MIN : BLANK_SEC;
    end

    running_d = (state_d == ST_RUN);
  end

  // Time, blink and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_q        <= '0;
      blink_phase_q <= 1'b0;
      blank_q       <= BLANK_NONE;
      running_q     <= 1'b0;
      sel_q         <= 1'b0;
    end else begin
      time_q        <= time_d;
      blink_phase_q <= blink_phase_d;
      blank_q       <= blank_d;
      running_q     <= running_d;
      sel_q         <= sw.sel_sw;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic      hold_q, hold_d;
  bcd_time_t disp_q, disp_d;

  // Lap hold: set from RUN, released by a second lap_btn, dropped by reset_btn/ADJUST
  always_comb begin
    hold_d = hold_q;
    if (sw.reset_btn || (state_d == ST_ADJUST)) begin
      hold_d = 1'b0;
    end else if (sw.lap_btn) begin
      if (hold_q) begin
        hold_d = 1'b0;
      end else if (state_q == ST_RUN) begin
        hold_d = 1'b1;
      end
    end
    disp_d = hold_d ? disp_q : time_d;
  end

  // Display-hold registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= 1'b0;
      disp_q <= '0;
    end else begin
      hold_q <= hold_d;
      disp_q <= disp_d;
    end
  end

  assign sw.min_tens = disp_q.min.tens;
  assign sw.min_ones = disp_q.min.ones;
  assign sw.sec_tens = disp_q.sec.tens;
  assign sw.sec_ones = disp_q.sec.ones;
`else
  assign sw.min_tens = time_q.min.tens;
  assign sw.min_ones = time_q.min.ones;
  assign sw.sec_tens = time_q.sec.tens;
  assign sw.sec_ones = time_q.sec.ones;
`endif

  assign sw.blank   = blank_q;
  assign sw.running = running_q;
  assign sw.state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with a seconds-level reference model.
module tb_stopwatch_ctrl;

  localparam int unsigned CNT_DIV   = 10;
  localparam int unsigned ADJ_DIV   = 4;
  localparam int unsigned BLINK_DIV = 3;

  logic clk = 1'b0;
  logic rst;

  stopwatch_ctrl_if sw();

  stopwatch_ctrl #(
    .CNT_DIV   (CNT_DIV),
    .ADJ_DIV   (ADJ_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 idle, 1 run, 2 pause, 3 adjust
  int         m_mode, m_min, m_sec, m_disp_min, m_disp_sec;
  int         m_run_el, m_adj_el, m_blink_el;
  bit         m_phase, m_prev_sel, m_hold;
  logic [3:0] m_blank;

  function automatic logic [15:0] to_bcd(input int mi, input int se);
    return {4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
  endfunction

  function automatic logic [15:0] dut_digits();
    return {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_min = 0; m_sec = 0; m_disp_min = 0; m_disp_sec = 0;
    m_run_el = 0; m_adj_el = 0; m_blink_el = 0;
    m_phase = 1'b0; m_prev_sel = 1'b0; m_hold = 1'b0; m_blank = 4'b0000;
  endtask

  // One clock of behaviour, computed from the inputs present at the edge
  task automatic model_step();
    int nm, t;
    bit run_tick, adj_tick, blink_tick, trans, sel_chg, lap;
`ifdef STOPWATCH_LAP_EN
    lap = sw.lap_btn;
`else
    lap = 1'b0;
`endif
    nm = m_mode;
    if (sw.reset_btn) nm = 0;
    else if (m_mode == 3) nm = sw.adj_sw ? 3 : 2;
    else if (sw.adj_sw) nm = 3;
    else if (sw.pause_btn) nm = (m_mode == 1) ? 2 : 1;

    sel_chg    = (sw.sel_sw != m_prev_sel);
    run_tick   = (m_mode == 1) && (((m_run_el + 1) % CNT_DIV) == 0);
    adj_tick   = (m_mode == 3) && (((m_adj_el + 1) % ADJ_DIV) == 0) && !sel_chg;
    blink_tick = (m_mode == 3) && (((m_blink_el + 1) % BLINK_DIV) == 0);
    trans      = (nm != m_mode) || sw.reset_btn;

    if (sw.reset_btn) begin
      m_min = 0; m_sec = 0;
    end else if (run_tick) begin
      t = (m_min * 60 + m_sec + 1) % 3600;
      m_min = t / 60; m_sec = t % 60;
    end else if (adj_tick) begin
      if (sw.sel_sw) m_min = (m_min + 1) % 60;
      else m_sec = (m_sec + 1) % 60;
    end

    m_run_el   = trans ? 0 : ((m_mode == 1) ? m_run_el + 1 : m_run_el);
    m_adj_el   = (trans || sel_chg) ? 0 : ((m_mode == 3) ? m_adj_el + 1 : m_adj_el);
    m_blink_el = trans ? 0 : ((m_mode == 3) ? m_blink_el + 1 : m_blink_el);
    m_phase    = (nm == 3) ? (m_phase ^ blink_tick) : 1'b0;
    m_blank    = m_phase ? (sw.sel_sw ? 4'b1100 : 4'b0011) : 4'b0000;
    m_prev_sel = sw.sel_sw;

    if (sw.reset_btn || nm == 3) m_hold = 1'b0;
    else if (lap) begin
      if (m_hold) m_hold = 1'b0;
      else if (m_mode == 1) m_hold = 1'b1;
    end
    if (!m_hold) begin
      m_disp_min = m_min; m_disp_sec = m_sec;
    end
    m_mode = nm;
  endtask

  // Drive inputs on the falling edge, clock once, return at the next falling edge
  task automatic drive_cycle(input bit pb, input bit rb, input bit adj, input bit sel, input bit lap);
    sw.pause_btn = pb;
    sw.reset_btn = rb;
    sw.adj_sw    = adj;
    sw.sel_sw    = sel;
`ifdef STOPWATCH_LAP_EN
    sw.lap_btn   = lap;
`else
    if (lap) $display("note: lap pulse ignored in this build");
`endif
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    sw.pause_btn = 1'b0; sw.reset_btn = 1'b0; sw.adj_sw = 1'b0; sw.sel_sw = 1'b0;
`ifdef STOPWATCH_LAP_EN
    sw.lap_btn = 1'b0;
`endif
    repeat (3) @(negedge clk);
    model_reset();
    rst = 1'b1;
    repeat (50) drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if (sw.state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", sw.state); end
    checks++;
    if (dut_digits() !== 16'h0000) begin errors++; $display("FAIL reset_digits: got %h want 0000", dut_digits()); end
    checks++;
    if (sw.blank !== 4'b0000) begin errors++; $display("FAIL reset_blank: got %b want 0000", sw.blank); end
    checks++;
    if (sw.running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", sw.running); end
  endtask

  task automatic test_count();
    drive_cycle(1, 0, 0, 0, 0);
    repeat (95) drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if (dut_digits() !== 16'h0009) begin errors++; $display("FAIL count_95: got %h want 0009", dut_digits()); end
    checks++;
    if (dut_digits() !== to_bcd(m_disp_min, m_disp_sec)) begin errors++; $display("FAIL count_model: got %h want %h", dut_digits(), to_bcd(m_disp_min, m_disp_sec)); end
    checks++;
    if ({sw.state, sw.running} !== 3'b011) begin errors++; $display("FAIL count_run: got %b want 011", {sw.state, sw.running}); end
    repeat (5) drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if (dut_digits() !== 16'h0010) begin errors++; $display("FAIL count_100: got %h want 0010", dut_digits()); end
    drive_cycle(1, 0, 0, 0, 0);
    checks++;
    if ({sw.state, sw.running} !== 3'b100) begin errors++; $display("FAIL pause_state: got %b want 100", {sw.state, sw.running}); end
    for (int i = 0; i < 100; i++) begin
      drive_cycle(0, 0, 0, 0, 0);
      checks++;
      if (dut_digits() !== 16'h0010) begin errors++; $display("FAIL pause_hold[%0d]: got %h want 0010", i, dut_digits()); end
    end
  endtask

  task automatic test_wrap();
    int n;
    drive_cycle(0, 0, 1, 1, 0);
    n = 0;
    while (m_min != 59 && n < 400) begin
      drive_cycle(0, 0, 1, 1, 0);
      n++;
      checks++;
      if (dut_digits() !== to_bcd(m_disp_min, m_disp_sec)) begin errors++; $display("FAIL preload_min: got %h want %h", dut_digits(), to_bcd(m_disp_min, m_disp_sec)); end
    end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL preload_min_timeout: got min %0d want 59", m_min); end
    n = 0;
    while (m_sec != 58 && n < 400) begin
      drive_cycle(0, 0, 1, 0, 0);
      n++;
      checks++;
      if (dut_digits() !== to_bcd(m_disp_min, m_disp_sec)) begin errors++; $display("FAIL preload_sec: got %h want %h", dut_digits(), to_bcd(m_disp_min, m_disp_sec)); end
    end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL preload_sec_timeout: got sec %0d want 58", m_sec); end
    drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if ({dut_digits(), sw.blank, sw.state} !== {16'h5958, 4'b0000, 2'b10}) begin
      errors++; $display("FAIL adjust_exit: got %h/%b/%b want 5958/0000/10", dut_digits(), sw.blank, sw.state);
    end
    drive_cycle(1, 0, 0, 0, 0);
    repeat (20) drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if ({dut_digits(), sw.running} !== {16'h0000, 1'b1}) begin
      errors++; $display("FAIL wrap_5959: got %h run=%b want 0000 run=1", dut_digits(), sw.running);
    end
  endtask

  task automatic test_adjust_min();
    int m0, s0, toggles;
    logic [3:0] prev_blank;
    drive_cycle(0, 0, 1, 1, 0);
    m0 = m_min; s0 = m_sec;
    prev_blank = sw.blank;
    toggles = 0;
    for (int i = 1; i <= 240; i++) begin
      drive_cycle(0, 0, 1, 1, 0);
      checks++;
      if (sw.blank !== m_blank || (sw.blank !== 4'b0000 && sw.blank !== 4'b1100)) begin
        errors++; $display("FAIL adj_blank[%0d]: got %b want %b", i, sw.blank, m_blank);
      end
      if (sw.blank !== prev_blank) toggles++;
      prev_blank = sw.blank;
      if (i == 120) begin
        checks++;
        if (dut_digits() !== to_bcd((m0 + 30) % 60, s0)) begin errors++; $display("FAIL adj_half: got %h want %h", dut_digits(), to_bcd((m0 + 30) % 60, s0)); end
      end
    end
    checks++;
    if (dut_digits() !== to_bcd(m0, s0)) begin errors++; $display("FAIL adj_wrap60: got %h want %h", dut_digits(), to_bcd(m0, s0)); end
    checks++;
    if (toggles != 80) begin errors++; $display("FAIL adj_blink_toggles: got %0d want 80", toggles); end
    drive_cycle(0, 0, 0, 1, 0);
    checks++;
    if ({sw.blank, sw.state} !== {4'b0000, 2'b10}) begin errors++; $display("FAIL adj_leave: got %b/%b want 0000/10", sw.blank, sw.state); end
  endtask

  task automatic test_reset_pause();
    drive_cycle(1, 0, 0, 1, 0);
    repeat (25) drive_cycle(0, 0, 0, 1, 0);
    drive_cycle(1, 1, 0, 1, 0);
    checks++;
    if ({dut_digits(), sw.state, sw.running} !== {16'h0000, 2'b00, 1'b0}) begin
      errors++; $display("FAIL reset_and_pause: got %h/%b/%b want 0000/00/0", dut_digits(), sw.state, sw.running);
    end
    drive_cycle(0, 1, 1, 1, 0);
    checks++;
    if (sw.state !== 2'b00) begin errors++; $display("FAIL reset_over_adj: got %b want 00", sw.state); end
    drive_cycle(0, 0, 1, 1, 0);
    checks++;
    if (sw.state !== 2'b11) begin errors++; $display("FAIL adj_after_reset: got %b want 11", sw.state); end
    drive_cycle(0, 0, 0, 1, 0);
  endtask

  task automatic test_rst_mid();
    drive_cycle(1, 0, 0, 1, 0);
    repeat (7) drive_cycle(0, 0, 0, 1, 0);
    rst = 1'b0;
    @(negedge clk);
    model_reset();
    checks++;
    if ({dut_digits(), sw.state} !== {16'h0000, 2'b00}) begin errors++; $display("FAIL rst_mid: got %h/%b want 0000/00", dut_digits(), sw.state); end
    rst = 1'b1;
    drive_cycle(1, 0, 0, 0, 0);
    repeat (CNT_DIV - 1) drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if (dut_digits() !== 16'h0000) begin errors++; $display("FAIL rst_mid_early: got %h want 0000", dut_digits()); end
    drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if (dut_digits() !== 16'h0001) begin errors++; $display("FAIL rst_mid_first_tick: got %h want 0001", dut_digits()); end
  endtask

  task automatic test_random();
    bit r_adj, r_sel, pb, rb, lp;
    logic [22:0] got, exp;
    r_adj = 1'b0; r_sel = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(29) == 0) r_adj = ~r_adj;
      if ($urandom_range(19) == 0) r_sel = ~r_sel;
      pb = ($urandom_range(5) == 0);
      rb = ($urandom_range(49) == 0);
`ifdef STOPWATCH_LAP_EN
      lp = ($urandom_range(14) == 0);
`else
      lp = 1'b0;
`endif
      drive_cycle(pb, rb, r_adj, r_sel, lp);
      got = {dut_digits(), sw.blank, sw.state, sw.running};
      exp = {to_bcd(m_disp_min, m_disp_sec), m_blank, 2'(m_mode), (m_mode == 1)};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL random[%0d]: got %h want %h", i, got, exp); end
    end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap();
    drive_cycle(0, 1, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0);
    repeat (50) drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if (dut_digits() !== 16'h0005) begin errors++; $display("FAIL lap_pre: got %h want 0005", dut_digits()); end
    drive_cycle(0, 0, 0, 0, 1);
    repeat (30) drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if (dut_digits() !== 16'h0005) begin errors++; $display("FAIL lap_hold: got %h want 0005", dut_digits()); end
    drive_cycle(0, 0, 0, 0, 1);
    checks++;
    if (dut_digits() !== 16'h0008) begin errors++; $display("FAIL lap_release: got %h want 0008", dut_digits()); end
  endtask
`endif

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_adjust_min();
    test_reset_pause();
    test_rst_mid();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
